qbert_move_tracker: RTL and testbench
=====================================

Name: qbert_move_tracker

Overview:
- Owns Q*bert's logical position on the pyramid and the per-cube colour state.
- Accepts jump requests from the game controller, times each hop in video frames, lands or falls, and updates cube colours.
- Drives position_qb, e_next_qb, e_color_state and done_move, which the cube renderer consumes to decide when to relatch top colours.

Parameters:
- ROWS, 7, pyramid rows; row r holds r+1 cubes.
- N_cube, 28, cube count; must equal ROWS*(ROWS+1)/2.
- MOVE_FRAMES, 4, frame_tick count per hop (≥1).
- FALL_FRAMES, 8, frame_tick count for an off-pyramid fall (≥1).
- TOGGLE, 0, landing colour rule: 0 sets the cube bit; 1 toggles it.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (reset=0 resets).
- frame_tick  in  1  one-cycle pulse per video frame.
- jump_req  in  1  one-cycle jump request.
- e_jump_qb  in  3  direction, sampled with jump_req: 1=up-right, 2=up-left, 3=down-right, 4=down-left; other codes are ignored.
- level_clear  in  1  synchronous level restart.
- position_qb  out  N_cube  one-hot current cube.
- e_next_qb  out  N_cube  one-hot target cube; equals position_qb when not hopping.
- e_color_state  out  N_cube  per-cube visited/colour bits.
- done_move  out  1  one-cycle pulse on landing.
- fell  out  1  one-cycle pulse when a fall completes.
- busy  out  1  high in MOVING or FALL.
- level_done  out  1  high while all N_cube colour bits are 1.

Behaviour:
- Cube indexing: idx = r*(r+1)/2 + c, with 0≤c≤r. Bit idx of each N_cube bus is that cube. Row and column are held internally and decoded to one-hot through a registered decode.
- Targets:
  - up-right: (r-1, c)
  - up-left: (r-1, c-1)
  - down-right: (r+1, c+1)
  - down-left: (r+1, c)
  - Off-pyramid if r<0, c<0, c>r, or r≥ROWS. Compute with signed or widened arithmetic; no wrap-around.
- Reset (async, reset=0) and level_clear (sync, highest priority among synchronous events):
  - position_qb = e_next_qb = bit0; e_color_state = 0; done_move = fell = busy = level_done = 0; state IDLE; frame counter 0.
  - level_clear has the same effect in any state, but as a synchronous action.
- IDLE:
  - jump_req with a valid code and an on-pyramid target: e_next_qb = target on the next edge, busy = 1, counter = MOVE_FRAMES, go to MOVING.
  - Valid code with an off-pyramid target: e_next_qb unchanged, busy = 1, counter = FALL_FRAMES, go to FALL.
  - Invalid code: ignored.
- MOVING:
  - Each frame_tick decrements the counter.
  - On the tick that makes the counter 0, go to LAND.
  - jump_req is ignored.
- LAND (one cycle), all on one edge:
  - position_qb = e_next_qb.
  - e_color_state[target] set, or toggled when TOGGLE=1.
  - done_move = 1 for exactly one cycle; busy = 0; go to IDLE.
  - The updated e_color_state and done_move become visible in the same cycle, so a consumer latching colours on done_move sees the new value.
- FALL:
  - Counts FALL_FRAMES frame_ticks.
  - Then on one edge: fell = 1 for one cycle; position_qb = e_next_qb = bit0; colours retained; busy = 0; go to IDLE.
- level_done:
  - Registered, equal to &e_color_state, updated one cycle after e_color_state.
  - With TOGGLE=1 it can deassert again.
- frame_tick and jump_req in the same cycle in IDLE: the jump is accepted and the tick is not counted.
- Reset mid-operation:
  - Asynchronous assertion forces all outputs to reset values immediately.
  - No pending done_move or fell is emitted after release.
- Invariant: outside MOVING/LAND, e_next_qb == position_qb; both are always one-hot.

Test Plan:
1. Release reset → position_qb = e_next_qb = 28'h0000001, e_color_state = 0, all pulses 0.
2. jump_req with e_jump_qb=3 from cube 0:
   - e_next_qb = 28'h0000004 one cycle later, busy = 1.
   - After 4 frame_ticks: position_qb = 28'h0000004, e_color_state = 28'h0000004, done_move high exactly 1 cycle, busy = 0.
3. jump_req with e_jump_qb=2 from cube 0:
   - FALL; after 8 frame_ticks fell pulses once.
   - position_qb = 28'h0000001; colours unchanged.
   - done_move never asserts.
4. Extra jump_req pulses and code 7 during MOVING → ignored: exactly one done_move, target unchanged, and code 7 in IDLE leaves the state unchanged.
5. Scripted path visiting all 28 cubes (TOGGLE=0) → level_done = 1 one cycle after the final landing; level_clear → e_color_state = 0, level_done = 0, position bit0.
6. Assert reset=0 after 2 frame_ticks of a hop → outputs at reset values immediately; after release, no done_move appears within 10 frame_ticks.

Source files
------------

// File: rtl/qbert_move_tracker.sv
// Q*bert pyramid position and cube-colour tracker: accepts hop requests, times
// each hop or fall in video frames, then lands (colouring the cube) or respawns at the apex.
module qbert_move_tracker #(
  parameter int ROWS        = 7,
  parameter int N_cube      = 28,
  parameter int MOVE_FRAMES = 4,
  parameter int FALL_FRAMES = 8,
  parameter bit TOGGLE      = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              jump_req,
  input  logic [2:0]        e_jump_qb,
  input  logic              level_clear,
  output logic [N_cube-1:0] position_qb,
  output logic [N_cube-1:0] e_next_qb,
  output logic [N_cube-1:0] e_color_state,
  output logic              done_move,
  output logic              fell,
  output logic              busy,
  output logic              level_done,
  output logic [1:0]        dbg_state
);

  localparam int RW = $clog2(ROWS + 1);
  localparam int MAXF = (MOVE_FRAMES > FALL_FRAMES) ? MOVE_FRAMES : FALL_FRAMES;
  localparam int CW = $clog2(MAXF + 1);
  localparam logic [N_cube-1:0] APEX = {{(N_cube-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_MOVING, S_LAND, S_FALL} state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [RW-1:0]     r_row, r_col, r_trow, r_tcol;
  logic [N_cube-1:0] r_pos, r_next, r_color, w_target_oh;
  logic              r_fell, r_level_done;
  logic              w_code_ok, w_off, w_accept, w_fall_start, w_land, w_fall_done, w_cnt_dec;
  int                w_dr, w_dc, w_tr, w_tc;

  function automatic logic [N_cube-1:0] f_onehot(input logic [RW-1:0] r, input logic [RW-1:0] c);
    int idx;
    idx = (int'(r) * (int'(r) + 1)) / 2 + int'(c);
    f_onehot = '0;
    for (int i = 0; i < N_cube; i++) f_onehot[i] = (i == idx);
  endfunction

  // Target is computed in signed 32-bit so moves off the top or sides go negative, never wrap.
  always_comb begin
    w_dr      = 0;
    w_dc      = 0;
    w_code_ok = 1'b1;
    case (e_jump_qb)
      3'd1:    w_dr = -1;
      3'd2:    begin w_dr = -1; w_dc = -1; end
      3'd3:    begin w_dr = 1;  w_dc = 1;  end
      3'd4:    w_dr = 1;
      default: w_code_ok = 1'b0;
    endcase
    w_tr        = int'(r_row) + w_dr;
    w_tc        = int'(r_col) + w_dc;
    w_off       = (w_tr < 0) || (w_tc < 0) || (w_tc > w_tr) || (w_tr >= ROWS);
    w_target_oh = f_onehot(RW'(w_tr), RW'(w_tc));
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_fall_start = 1'b0;
    w_land       = 1'b0;
    w_fall_done  = 1'b0;
    w_cnt_dec    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (jump_req && w_code_ok) begin
          if (w_off) begin
            w_state_nxt  = S_FALL;
            w_fall_start = 1'b1;
          end else begin
            w_state_nxt = S_MOVING;
            w_accept    = 1'b1;
          end
        end
      end
      S_MOVING: begin
        if (frame_tick) begin
          if (r_cnt == CW'(1)) begin
            w_state_nxt = S_LAND;
            w_land      = 1'b1;
          end else begin
            w_cnt_dec = 1'b1;
          end
        end
      end
      S_LAND: w_state_nxt = S_IDLE;
      S_FALL: begin
        if (frame_tick) begin
          if (r_cnt == CW'(1)) begin
            w_state_nxt = S_IDLE;
            w_fall_done = 1'b1;
          end else begin
            w_cnt_dec = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_trow       <= '0;
      r_tcol       <= '0;
      r_pos        <= APEX;
      r_next       <= APEX;
      r_color      <= '0;
      r_fell       <= 1'b0;
      r_level_done <= 1'b0;
    end else if (level_clear) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_trow       <= '0;
      r_tcol       <= '0;
      r_pos        <= APEX;
      r_next       <= APEX;
      r_color      <= '0;
      r_fell       <= 1'b0;
      r_level_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_fell       <= w_fall_done;
      r_level_done <= &r_color;
      if (w_accept) begin
        r_next <= w_target_oh;
        r_trow <= RW'(w_tr);
        r_tcol <= RW'(w_tc);
        r_cnt  <= CW'(MOVE_FRAMES);
      end
      if (w_fall_start) r_cnt <= CW'(FALL_FRAMES);
      if (w_cnt_dec) r_cnt <= r_cnt - CW'(1);
      // Colour and position change on the same edge that raises done_move.
      if (w_land) begin
        r_pos   <= r_next;
        r_row   <= r_trow;
        r_col   <= r_tcol;
        r_color <= TOGGLE ? (r_color ^ r_next) : (r_color | r_next);
        r_cnt   <= '0;
      end
      if (w_fall_done) begin
        r_pos  <= APEX;
        r_next <= APEX;
        r_row  <= '0;
        r_col  <= '0;
        r_cnt  <= '0;
      end
    end
  end

  assign position_qb   = r_pos;
  assign e_next_qb     = r_next;
  assign e_color_state = r_color;
  assign done_move     = (r_state == S_LAND);
  assign fell          = r_fell;
  assign busy          = (r_state == S_MOVING) || (r_state == S_FALL);
  assign level_done    = r_level_done;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_qbert_move_tracker.sv
// Randomized hop/fall bench for qbert_move_tracker against a row/column pyramid model.
module tb_qbert_move_tracker;
  localparam int ROWS = 7;
  localparam int N    = 28;
  localparam int MF   = 4;
  localparam int FF   = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         frame_tick = 1'b0;
  logic         jump_req = 1'b0;
  logic [2:0]   e_jump_qb = 3'd0;
  logic         level_clear = 1'b0;
  logic [N-1:0] position_qb, e_next_qb, e_color_state;
  logic         done_move, fell, busy, level_done;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;
  int fell_seen = 0;
  int m_r = 0;
  int m_c = 0;
  logic [N-1:0] m_color = '0;

  qbert_move_tracker dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .jump_req(jump_req),
    .e_jump_qb(e_jump_qb), .level_clear(level_clear), .position_qb(position_qb),
    .e_next_qb(e_next_qb), .e_color_state(e_color_state), .done_move(done_move),
    .fell(fell), .busy(busy), .level_done(level_done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done_move) done_seen++;
    if (fell) fell_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] cube(input int r, input int c);
    logic [N-1:0] one;
    one = 1;
    return one << (r * (r + 1) / 2 + c);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap(input bit noise);
    int n;
    n = $urandom_range(0, 2);
    for (int k = 0; k < n; k++) begin
      if (noise && ($urandom_range(0, 1) == 1)) begin
        jump_req  = 1'b1;
        e_jump_qb = 3'($urandom_range(0, 7));
      end
      step();
      jump_req = 1'b0;
    end
  endtask

  task automatic do_jump(input logic [2:0] code, input bit noise);
    int dr, dc, tr, tc, nt, d0, f0;
    bit ok, off, all_old;
    logic [N-1:0] pos0, col0, tgt;
    dr = 0; dc = 0; ok = 1'b1;
    case (code)
      3'd1: dr = -1;
      3'd2: begin dr = -1; dc = -1; end
      3'd3: begin dr = 1; dc = 1; end
      3'd4: dr = 1;
      default: ok = 1'b0;
    endcase
    pos0 = cube(m_r, m_c);
    col0 = m_color;
    d0 = done_seen;
    f0 = fell_seen;
    jump_req   = 1'b1;
    e_jump_qb  = code;
    frame_tick = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    step();
    jump_req   = 1'b0;
    frame_tick = 1'b0;
    if (!ok) begin
      check("bad_code_pos", position_qb, pos0);
      check("bad_code_next", e_next_qb, pos0);
      check("bad_code_busy", busy, 0);
      return;
    end
    tr  = m_r + dr;
    tc  = m_c + dc;
    off = (tr < 0) || (tc < 0) || (tc > tr) || (tr >= ROWS);
    tgt = off ? pos0 : cube(tr, tc);
    check("accept_next", e_next_qb, tgt);
    check("accept_pos", position_qb, pos0);
    check("accept_busy", busy, 1);
    nt = off ? FF : MF;
    for (int i = 0; i < nt; i++) begin
      idle_gap(noise);
      if (i == nt - 1) begin
        check("hold_next", e_next_qb, tgt);
        check("no_early_pulse", (done_seen - d0) + (fell_seen - f0), 0);
      end
      frame_tick = 1'b1;
      if (noise && ($urandom_range(0, 1) == 1)) begin
        jump_req  = 1'b1;
        e_jump_qb = 3'($urandom_range(0, 7));
      end
      step();
      frame_tick = 1'b0;
      jump_req   = 1'b0;
    end
    if (!off) begin
      m_r = tr;
      m_c = tc;
      all_old = &m_color;
      m_color = m_color | tgt;
      check("land_done", done_move, 1);
      check("land_pos", position_qb, tgt);
      check("land_next", e_next_qb, tgt);
      check("land_color", e_color_state, m_color);
      check("land_busy", busy, 0);
      check("land_lvl_lag", level_done, all_old);
    end else begin
      m_r = 0;
      m_c = 0;
      check("fall_fell", fell, 1);
      check("fall_pos", position_qb, cube(0, 0));
      check("fall_next", e_next_qb, cube(0, 0));
      check("fall_color", e_color_state, col0);
      check("fall_busy", busy, 0);
    end
    step();
    check("pulse_done_low", done_move, 0);
    check("pulse_fell_low", fell, 0);
    check("level_done", level_done, &m_color);
    check("done_count", done_seen - d0, off ? 0 : 1);
    check("fell_count", fell_seen - f0, off ? 1 : 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pos"}, position_qb, cube(0, 0));
    check({tag, "_next"}, e_next_qb, cube(0, 0));
    check({tag, "_color"}, e_color_state, 0);
    check({tag, "_done"}, done_move, 0);
    check({tag, "_fell"}, fell, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_lvl"}, level_done, 0);
  endtask

  initial begin
    int d0, f0;
    step();
    step();
    reset = 1'b1;
    step();
    check_reset_vals("rst");

    do_jump(3'd3, 1'b0);
    do_jump(3'd1, 1'b0);
    do_jump(3'd2, 1'b0);
    do_jump(3'd4, 1'b1);
    do_jump(3'd7, 1'b0);
    do_jump(3'd0, 1'b0);

    for (int i = 0; i < 40; i++)
      do_jump(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));

    level_clear = 1'b1;
    step();
    level_clear = 1'b0;
    m_r = 0; m_c = 0; m_color = '0;
    check_reset_vals("clr0");

    for (int c = 0; c < ROWS; c++) begin
      for (int k = c; k < ROWS - 1; k++) do_jump(3'd4, 1'b0);
      for (int k = c; k < ROWS - 1; k++) do_jump(3'd1, 1'b0);
      if (c < ROWS - 1) do_jump(3'd3, 1'b0);
    end
    check("all_colored", e_color_state, {N{1'b1}});
    check("level_done_set", level_done, 1);

    level_clear = 1'b1;
    step();
    level_clear = 1'b0;
    m_r = 0; m_c = 0; m_color = '0;
    check_reset_vals("clr1");

    do_jump(3'd3, 1'b0);
    jump_req  = 1'b1;
    e_jump_qb = 3'd4;
    step();
    jump_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
    check("mid_hop_busy", busy, 1);
    #3;
    reset = 1'b0;
    #1;
    check_reset_vals("async");
    m_r = 0; m_c = 0; m_color = '0;
    step();
    step();
    reset = 1'b1;
    d0 = done_seen;
    f0 = fell_seen;
    for (int i = 0; i < 10; i++) begin
      idle_gap(1'b0);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
    end
    step();
    check("post_rst_done", done_seen - d0, 0);
    check("post_rst_fell", fell_seen - f0, 0);
    check_reset_vals("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
